// File: rtl/mario_wavrom_arbiter.sv
// rtl/mario_wavrom_arbiter.sv - round-robin arbiter sharing the wave-sample ROM read port
// Optional MARIO_WAVROM_CH0_PRIO_EN: channel 0 (skid) pre-empts the rotation in IDLE.
module mario_wavrom_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int CHW     = 2,
  parameter int AW      = 13,
  parameter int DW      = 16,
  parameter int ROM_LAT = 1
) (
  input  logic                 I_CLK,
  input  logic                 I_RESET,
  input  logic [NUM_CH-1:0]    I_REQ,
  input  logic [NUM_CH*AW-1:0] I_ADDR,
  output logic [NUM_CH-1:0]    O_ACK,
  output logic [DW-1:0]        O_DATA,
  output logic [CHW-1:0]       O_CH,
  output logic                 O_BUSY,
  output logic [AW-1:0]        O_ROM_ADDR,
  output logic                 O_ROM_RD,
  input  logic [DW-1:0]        I_ROM_DATA
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic [DW-1:0]       data_q, data_d;
  logic [CHW-1:0]      ch_q, ch_d;
  logic [CHW-1:0]      ptr_q, ptr_d;
  logic [AW-1:0]       rom_addr_q, rom_addr_d;
  logic                rom_rd_q, rom_rd_d;
  logic [3:0]          cnt_q, cnt_d;

  logic [CHW-1:0]      win_idx;
  logic [CHW-1:0]      idx;
  logic                win_found;
  logic                capture;

  // Winner: first requester at or above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CHW'((int'(ptr_q) + i) % NUM_CH);
      if (!win_found && I_REQ[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
`ifdef MARIO_WAVROM_CH0_PRIO_EN
    if (I_REQ[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      data_q     <= '0;
      ch_q       <= '0;
      ptr_q      <= '0;
      rom_addr_q <= '0;
      rom_rd_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      ch_q       <= ch_d;
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      rom_rd_q   <= rom_rd_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (win_found) state_d = READ;
      READ: state_d = (ROM_LAT == 1) ? DONE : WAIT;
      WAIT: if (cnt_q == 4'd1) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Data is captured on the edge that enters DONE, ROM_LAT edges after the grant.
  assign capture = ((state_q == READ) && (ROM_LAT == 1)) ||
                   ((state_q == WAIT) && (cnt_q == 4'd1));

  always_comb begin
    ack_d      = '0;
    data_d     = data_q;
    ch_d       = ch_q;
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    rom_rd_d   = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          ch_d       = win_idx;
          rom_addr_d = I_ADDR[int'(win_idx)*AW +: AW];
          rom_rd_d   = 1'b1;
        end
      end
      READ: cnt_d = 4'(ROM_LAT - 1);
      WAIT: cnt_d = cnt_q - 4'd1;
      DONE: begin
`ifdef MARIO_WAVROM_CH0_PRIO_EN
        if (ch_q != '0)
          ptr_d = (int'(ch_q) == NUM_CH - 1) ? '0 : ch_q + 1'b1;
`else
        ptr_d = (int'(ch_q) == NUM_CH - 1) ? '0 : ch_q + 1'b1;
`endif
      end
      default: ;
    endcase
    if (capture) begin
      ack_d[ch_q] = 1'b1;
      data_d      = I_ROM_DATA;
    end
  end

  assign O_ACK      = ack_q;
  assign O_DATA     = data_q;
  assign O_CH       = ch_q;
  assign O_BUSY     = (state_q != IDLE);
  assign O_ROM_ADDR = rom_addr_q;
  assign O_ROM_RD   = rom_rd_q;

endmodule

// File: tb/tb_mario_wavrom_arbiter.sv
// tb/tb_mario_wavrom_arbiter.sv - randomized scoreboard bench for mario_wavrom_arbiter
module tb_mario_wavrom_arbiter;
  localparam int N   = 4;
  localparam int CHW = 2;
  localparam int AW  = 13;
  localparam int DW  = 16;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    ack;
  logic [DW-1:0]   data;
  logic [CHW-1:0]  ch;
  logic            busy;
  logic [AW-1:0]   rom_addr;
  logic            rom_rd;
  logic [DW-1:0]   rom_data;

  mario_wavrom_arbiter #(.NUM_CH(N), .CHW(CHW), .AW(AW), .DW(DW), .ROM_LAT(LAT)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_REQ(req), .I_ADDR(addr),
    .O_ACK(ack), .O_DATA(data), .O_CH(ch), .O_BUSY(busy),
    .O_ROM_ADDR(rom_addr), .O_ROM_RD(rom_rd), .I_ROM_DATA(rom_data)
  );

  assign rom_data = {3'b000, rom_addr};

  always #5 clk = ~clk;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;
  int            ptr_m = 0;
  int            next_free = 0;
  bit            granted = 0;
  int            last_grant = 0;
  logic [AW-1:0] last_addr = '0;
  int            grants[N];
  bit            drive_en = 0;
  int            prob = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one access per LAT+2 cycles, winner chosen by rotation from the pointer.
  always @(posedge clk) begin
    if (rst) begin
      ptr_m     = 0;
      next_free = cyc + 1;
      granted   = 0;
      sb.delete();
    end else if (cyc >= next_free && req != '0) begin : grant_blk
      int g;
      g = -1;
`ifdef MARIO_WAVROM_CH0_PRIO_EN
      if (req[0]) g = 0;
`endif
      for (int k = 0; k < N; k++)
        if (g < 0 && req[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      last_addr  = addr[g*AW +: AW];
      sb.push_back('{g, {3'b000, last_addr}, cyc + LAT + 1});
      last_grant = cyc;
      granted    = 1;
      next_free  = cyc + LAT + 2;
      grants[g]++;
`ifdef MARIO_WAVROM_CH0_PRIO_EN
      if (g != 0) ptr_m = (g + 1) % N;
`else
      ptr_m = (g + 1) % N;
`endif
    end
    cyc++;
  end

  // Monitor compares against the scoreboard, then the requesters react.
  always @(negedge clk) begin
    bit busy_e;
    bit rd_e;
    exp_t e;
    busy_e = granted && (cyc >= last_grant + 1) && (cyc <= last_grant + LAT + 1);
    rd_e   = granted && (cyc == last_grant + 1);
    chk("busy", 32'(busy), 32'(busy_e));
    chk("rom_rd", 32'(rom_rd), 32'(rd_e));
    if (rd_e) chk("rom_addr", 32'(rom_addr), 32'(last_addr));
    if (ack != '0) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got %0h expected none (cycle %0d)", ack, cyc);
      end else begin
        e = sb.pop_front();
        chk("ack_onehot", 32'(ack), 32'(1) << e.ch);
        chk("ack_data", 32'(data), 32'(e.data));
        chk("ack_cycle", cyc, e.due);
        chk("o_ch", 32'(ch), e.ch);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      tests++;
      fails++;
      $display("FAIL missing_ack: got none expected ch %0d (cycle %0d)", sb[0].ch, cyc);
      sb.delete(0);
    end
    if (drive_en) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(99) < prob) begin
          addr[i*AW +: AW] = AW'($urandom);
          req[i] = 1'b1;
        end
      end
    end
  end

  initial begin
    bit hit;
    for (int i = 0; i < N; i++) grants[i] = 0;
    rst  = 1'b1;
    addr = '0;
    addr[0*AW +: AW] = 13'h0123;
    addr[1*AW +: AW] = 13'h0800;
    req  = 4'b0011;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_ch", 32'(ch), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_rom_rd", 32'(rom_rd), 0);
    chk("rst_busy", 32'(busy), 0);
    rst      = 1'b0;
    drive_en = 1;
    prob     = 0;
    @(negedge clk);
    chk("first_rd", 32'(rom_rd), 1);
    chk("first_ch", 32'(ch), 0);
    chk("first_addr", 32'(rom_addr), 32'h0123);
    repeat (20) @(negedge clk);

    prob = 30;
    repeat (1500) @(negedge clk);
    prob = 100;
    repeat (400) @(negedge clk);

    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (granted && cyc == last_grant + 2) hit = 1;
    end
    chk("reach_wait", 32'(hit), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);

    prob = 30;
    repeat (500) @(negedge clk);
    prob = 0;
    repeat (40) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    for (int i = 0; i < N; i++) chk("served", 32'(grants[i] > 0), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
